uart_cmd_master: RTL and testbench
==================================

Name: uart_cmd_master

Overview:
- Host-side initiator for the UART command protocol consumed by sys_ctrl.
- Accepts one command request at a time and serialises it into a framed byte stream for a UART transmitter (byte-level valid/ready).
- Collects the response bytes returned by the system's UART TX path and presents one assembled response word.
- Sits in the host/test-harness domain, between a command source and a uart_tx/uart_rx byte pair.

Parameters:
- DATA_WIDTH, 8, byte width of the serial payload.
- ADDR_WIDTH, 4, register-file address width; zero-extended to one byte on the wire.
- FUN_WIDTH, 4, ALU function width; zero-extended to one byte on the wire.
- TMO_WIDTH, 16, width of the response timeout counter.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request valid.
- cmd_ready  out  1  high only in IDLE; the command is accepted when cmd_valid&&cmd_ready.
- cmd_type  in  2  0=RF_WR, 1=RF_RD, 2=ALU_OP (with operands), 3=ALU_NOP (no operands).
- cmd_addr  in  ADDR_WIDTH  RF address.
- cmd_wdata  in  DATA_WIDTH  RF write data, or ALU operand A.
- cmd_opb  in  DATA_WIDTH  ALU operand B.
- cmd_fun  in  FUN_WIDTH  ALU function code.
- tx_byte  out  DATA_WIDTH  byte offered to the UART transmitter.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid&&tx_ready.
- rx_byte  in  DATA_WIDTH  byte from the UART receiver.
- rx_valid  in  1  single-cycle strobe per received byte.
- rsp_valid  out  1  one-cycle pulse when a response or completion is available.
- rsp_data  out  2*DATA_WIDTH  response data.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout or stray byte.
- tmo_limit  in  TMO_WIDTH  timeout in clk cycles (used only under RSP_TIMEOUT_EN).

Behaviour:
- Reset (synchronous, active-high) forces:
  - state=IDLE.
  - cmd_ready=1, tx_valid=0, tx_byte=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - internal counters=0.
- On acceptance, all command fields are registered; inputs are don't-care afterwards.
- Frames, bytes sent in order:
  - RF_WR: 0xAA, addr, data. No response.
  - RF_RD: 0xBB, addr. 1 response byte.
  - ALU_OP: 0xCC, A, B, fun. 2 response bytes, LSB first.
  - ALU_NOP: 0xDD, fun. 2 response bytes, LSB first.
- States: IDLE -> SEND -> (WAIT_RSP | DONE) -> IDLE.
- SEND:
  - tx_valid=1 and tx_byte=frame[idx].
  - idx advances only on tx_valid&&tx_ready.
  - tx_byte is held stable while tx_ready=0.
  - First tx_valid is asserted the cycle after acceptance.
  - After the last byte handshakes: RF_WR goes to DONE; all other types go to WAIT_RSP with the expected count set to 1 or 2.
- WAIT_RSP:
  - Each rx_valid stores rx_byte.
  - Byte 0 goes to rsp_data[7:0]; byte 1 goes to rsp_data[15:8].
  - For RF_RD, rsp_data[15:8]=0.
  - When the final expected byte arrives, go to DONE.
- DONE: single cycle; rsp_valid=1, then IDLE.
  - RF_WR completes with rsp_data=0 and rsp_err=0.
  - rsp_data holds its value until the next acceptance.
- rx_valid in IDLE or SEND (stray byte): byte is discarded and a one-cycle rsp_valid with rsp_err=1 and rsp_data={8'h00, rx_byte} is raised.
  - In SEND this error pulse does not disturb transmission.
  - A transaction's own completion pulse never coincides with a stray-byte pulse. If both would occur in the same cycle, completion wins and the stray error is dropped.
- rx_valid in the same cycle as the final tx handshake belongs to no transaction and is treated as stray.
- Reset mid-frame: abandons the frame immediately; tx_valid drops in the next cycle.

Optional Feature:
- Macro: RSP_TIMEOUT_EN.
- Defined:
  - A TMO_WIDTH counter clears on entry to WAIT_RSP and on each rx_valid, and increments otherwise.
  - When it reaches tmo_limit, go to DONE with rsp_err=1 and the partial rsp_data kept.
  - tmo_limit=0 disables the timeout.
- Not defined:
  - No counter; WAIT_RSP waits indefinitely.
  - tmo_limit is ignored.
  - rsp_err is raised only for stray bytes.

Test Plan:
- RF_WR addr=3 data=0x5A, tx_ready always 1 -> bytes AA,03,5A on consecutive cycles; rsp_valid with rsp_data=0x0000, rsp_err=0; cmd_ready returns 1.
- RF_RD addr=2, tx_ready toggling 1/0, then rx_byte 0x81 -> bytes BB,02 held stable across stalls; rsp_data=0x0081.
- ALU_OP A=0x12 B=0x34 fun=0, rx bytes 0x46 then 0x00 -> bytes CC,12,34,00; rsp_data=0x0046. ALU_NOP fun=2, rx bytes 0x48, 0x03 -> bytes DD,02; rsp_data=0x0348.
- Stray rx_byte 0x77 in IDLE -> rsp_valid with rsp_err=1, rsp_data=0x0077; state stays IDLE.
- RSP_TIMEOUT_EN, tmo_limit=10, RF_RD with no reply -> rsp_err=1 exactly 10 cycles after entering WAIT_RSP. Without the macro -> no rsp_valid after 1000 cycles.
- rst asserted during SEND of an ALU_OP after 2 bytes -> tx_valid=0 next cycle; cmd_ready=1; the next command starts cleanly with its header byte.

Source files
------------

// File: rtl/uart_cmd_master.sv
// rtl/uart_cmd_master.sv - UART command-frame initiator with response collection
// Optional response timeout enabled by defining RSP_TIMEOUT_EN.
module uart_cmd_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_type,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH-1:0]   cmd_opb,
    input  logic [FUN_WIDTH-1:0]    cmd_fun,
    output logic [DATA_WIDTH-1:0]   tx_byte,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [DATA_WIDTH-1:0]   rx_byte,
    input  logic                    rx_valid,
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    rsp_err,
    input  logic [TMO_WIDTH-1:0]    tmo_limit
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

    localparam logic [1:0] T_RF_WR  = 2'd0;
    localparam logic [1:0] T_RF_RD  = 2'd1;
    localparam logic [1:0] T_ALU_OP = 2'd2;

    localparam logic [DATA_WIDTH-1:0] HDR_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_NOP = DATA_WIDTH'(8'hDD);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   payload [3];
    logic [1:0]              idx;
    logic [1:0]              left;
    logic                    is_wr;
    logic                    two_bytes;
    logic                    rx_cnt;
    logic [2*DATA_WIDTH-1:0] rsp_buf;
    logic [DATA_WIDTH-1:0]   addr_b;
    logic [DATA_WIDTH-1:0]   fun_b;

    assign addr_b = DATA_WIDTH'(cmd_addr);
    assign fun_b  = DATA_WIDTH'(cmd_fun);

`ifdef RSP_TIMEOUT_EN
    logic [TMO_WIDTH-1:0] tmo_cnt;
`else
    logic unused_tmo_limit;
    assign unused_tmo_limit = ^tmo_limit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            tx_valid  <= 1'b0;
            tx_byte   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            idx       <= '0;
            left      <= '0;
            is_wr     <= 1'b0;
            two_bytes <= 1'b0;
            rx_cnt    <= 1'b0;
            rsp_buf   <= '0;
            for (int i = 0; i < 3; i++) payload[i] <= '0;
`ifdef RSP_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            // Stray report is assigned first so a completion written below overrides it.
            if (rx_valid && state != WAIT_RSP) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_data  <= {{DATA_WIDTH{1'b0}}, rx_byte};
            end
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        tx_valid  <= 1'b1;
                        state     <= SEND;
                        idx       <= '0;
                        is_wr     <= (cmd_type == T_RF_WR);
                        two_bytes <= cmd_type[1];
                        case (cmd_type)
                            T_RF_WR: begin
                                tx_byte    <= HDR_WR;
                                payload[0] <= addr_b;
                                payload[1] <= cmd_wdata;
                                left       <= 2'd2;
                            end
                            T_RF_RD: begin
                                tx_byte    <= HDR_RD;
                                payload[0] <= addr_b;
                                left       <= 2'd1;
                            end
                            T_ALU_OP: begin
                                tx_byte    <= HDR_OP;
                                payload[0] <= cmd_wdata;
                                payload[1] <= cmd_opb;
                                payload[2] <= fun_b;
                                left       <= 2'd3;
                            end
                            default: begin
                                tx_byte    <= HDR_NOP;
                                payload[0] <= fun_b;
                                left       <= 2'd1;
                            end
                        endcase
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (left == 2'd0) begin
                            tx_valid <= 1'b0;
                            if (is_wr) begin
                                state     <= DONE;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b0;
                                rsp_data  <= '0;
                            end else begin
                                state   <= WAIT_RSP;
                                rx_cnt  <= 1'b0;
                                rsp_buf <= '0;
`ifdef RSP_TIMEOUT_EN
                                tmo_cnt <= '0;
`endif
                            end
                        end else begin
                            tx_byte <= payload[idx];
                            idx     <= idx + 2'd1;
                            left    <= left - 2'd1;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (rx_valid) begin
                        rx_cnt <= 1'b1;
`ifdef RSP_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (rx_cnt) rsp_buf[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_byte;
                        else        rsp_buf[DATA_WIDTH-1:0]            <= rx_byte;
                        if (rx_cnt || !two_bytes) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= rx_cnt ? {rx_byte, rsp_buf[DATA_WIDTH-1:0]}
                                                : {{DATA_WIDTH{1'b0}}, rx_byte};
                        end
                    end
`ifdef RSP_TIMEOUT_EN
                    else if (tmo_limit != '0 && tmo_cnt + TMO_WIDTH'(1) == tmo_limit) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= rsp_buf;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
                    end
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb/tb_uart_cmd_master.sv - self-checking bench for uart_cmd_master
module tb_uart_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = '0;
    logic [3:0]  cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic [7:0]  cmd_opb = '0;
    logic [3:0]  cmd_fun = '0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] tmo_limit = '0;

    uart_cmd_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_opb(cmd_opb), .cmd_fun(cmd_fun),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tmo_limit(tmo_limit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  t;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  opb;
        logic [3:0]  fun;
        int          nrx;
        logic [7:0]  rx0;
        logic [7:0]  rx1;
        logic [31:0] frame;
        int          len;
        logic [15:0] rsp;
        int          mode;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ready_mode = 0;
    int stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte = '0;
    logic [7:0]  tx_q[$];
    int          tx_cyc[$];
    logic [16:0] rsp_q[$];
    vec_t        vecs[6];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || tx_byte !== prev_byte)) stall_bad++;
            if (tx_valid && tx_ready) begin
                tx_q.push_back(tx_byte);
                tx_cyc.push_back(cyc);
            end
            if (rsp_valid) rsp_q.push_back({rsp_err, rsp_data});
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame and response derived directly from the protocol table.
    function automatic vec_t model(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wdata,
                                   input logic [7:0] opb, input logic [3:0] fun,
                                   input logic [7:0] rx0, input logic [7:0] rx1, input int mode);
        vec_t v;
        v.t = t; v.addr = addr; v.wdata = wdata; v.opb = opb; v.fun = fun;
        v.rx0 = rx0; v.rx1 = rx1; v.mode = mode;
        case (t)
            2'd0: begin v.frame = {8'h00, wdata, 4'h0, addr, 8'hAA}; v.len = 3; v.nrx = 0; v.rsp = 16'h0; end
            2'd1: begin v.frame = {16'h0, 4'h0, addr, 8'hBB};        v.len = 2; v.nrx = 1; v.rsp = {8'h00, rx0}; end
            2'd2: begin v.frame = {4'h0, fun, opb, wdata, 8'hCC};    v.len = 4; v.nrx = 2; v.rsp = {rx1, rx0}; end
            default: begin v.frame = {16'h0, 4'h0, fun, 8'hDD};      v.len = 2; v.nrx = 2; v.rsp = {rx1, rx0}; end
        endcase
        return v;
    endfunction

    task automatic issue_cmd(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] wdata,
                             input logic [7:0] opb, input logic [3:0] fun);
        int n = 0;
        while (!cmd_ready && n < 100) begin tick(); n++; end
        if (n >= 100) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_type = t; cmd_addr = addr; cmd_wdata = wdata; cmd_opb = opb; cmd_fun = fun;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        acc_cyc = cyc;
        cmd_type = 2'($urandom); cmd_addr = 4'($urandom); cmd_wdata = 8'($urandom);
        cmd_opb = 8'($urandom); cmd_fun = 4'($urandom);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int b = 0;
        while (tx_q.size() < n && b < 200) begin tick(); b++; end
        if (b >= 200) check({tag, "_tx_timeout"}, tx_q.size(), n);
    endtask

    task automatic wait_rsp(input int n, input string tag);
        int b = 0;
        while (rsp_q.size() < n && b < 200) begin tick(); b++; end
        if (b >= 200) check({tag, "_rsp_timeout"}, rsp_q.size(), n);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_byte = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        tx_q.delete(); tx_cyc.delete(); rsp_q.delete();
        stall_bad = 0;
        ready_mode = v.mode;
        issue_cmd(v.t, v.addr, v.wdata, v.opb, v.fun);
        wait_tx(v.len, tag);
        check({tag, "_len"}, tx_q.size(), v.len);
        for (int i = 0; i < v.len; i++) check({tag, "_byte"}, 32'(tx_q[i]), 32'(v.frame[8*i +: 8]));
        if (v.mode == 0) begin
            check({tag, "_first_tx"}, tx_cyc[0], acc_cyc);
            check({tag, "_consecutive"}, tx_cyc[v.len-1] - tx_cyc[0], v.len - 1);
        end
        for (int r = 0; r < v.nrx; r++) begin
            repeat ($urandom_range(0, 2)) tick();
            push_rx(r == 0 ? v.rx0 : v.rx1);
        end
        wait_rsp(1, tag);
        tick(); tick();
        check({tag, "_rsp_count"}, rsp_q.size(), 1);
        check({tag, "_rsp"}, 32'(rsp_q[0]), {15'd0, 1'b0, v.rsp});
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_stall_hold"}, stall_bad, 0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, 0, 8'h00, 8'h00, 32'h005A03AA, 3, 16'h0000, 0};
        vecs[1] = '{2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1, 8'h81, 8'h00, 32'h000002BB, 2, 16'h0081, 1};
        vecs[2] = '{2'd2, 4'h0, 8'h12, 8'h34, 4'h0, 2, 8'h46, 8'h00, 32'h003412CC, 4, 16'h0046, 0};
        vecs[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'h2, 2, 8'h48, 8'h03, 32'h000002DD, 2, 16'h0348, 0};
        vecs[4] = '{2'd0, 4'hF, 8'hFF, 8'h00, 4'h0, 0, 8'h00, 8'h00, 32'h00FF0FAA, 3, 16'h0000, 2};
        vecs[5] = '{2'd2, 4'h0, 8'hFF, 8'h01, 4'hF, 2, 8'h00, 8'h01, 32'h0F01FFCC, 4, 16'h0100, 1};

        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Stray byte while idle
        rsp_q.delete();
        push_rx(8'h77);
        wait_rsp(1, "stray_idle");
        check("stray_idle_rsp", 32'(rsp_q[0]), 32'h1_0077);
        tick(); tick();
        check("stray_idle_ready", 32'(cmd_ready), 32'd1);
        check("stray_idle_txv", 32'(tx_valid), 32'd0);

        // Stray byte mid-SEND must not disturb the frame
        tx_q.delete(); rsp_q.delete(); stall_bad = 0;
        ready_mode = 1;
        issue_cmd(2'd2, 4'h0, 8'hA1, 8'hB2, 4'h7);
        tick();
        push_rx(8'h5C);
        wait_tx(4, "stray_send");
        check("stray_send_b0", 32'(tx_q[0]), 32'hCC);
        check("stray_send_b3", 32'(tx_q[3]), 32'h07);
        push_rx(8'h10);
        push_rx(8'h20);
        wait_rsp(2, "stray_send");
        check("stray_send_err", 32'(rsp_q[0]), 32'h1_005C);
        check("stray_send_done", 32'(rsp_q[1]), 32'h0_2010);
        check("stray_send_stall", stall_bad, 0);

        // Stray on the final RF_WR handshake collides with completion: completion wins
        ready_mode = 0;
        tick(); tick();
        tx_q.delete(); rsp_q.delete();
        issue_cmd(2'd0, 4'h9, 8'h66, 8'h00, 4'h0);
        tick(); tick();
        push_rx(8'hE1);
        repeat (5) tick();
        check("wr_collide_count", rsp_q.size(), 1);
        check("wr_collide_rsp", 32'(rsp_q[0]), 32'h0_0000);

        // Stray on the final RF_RD handshake is not a response byte
        tx_q.delete(); rsp_q.delete();
        issue_cmd(2'd1, 4'h4, 8'h00, 8'h00, 4'h0);
        tick();
        push_rx(8'hE5);
        push_rx(8'h11);
        wait_rsp(2, "rd_collide");
        check("rd_collide_err", 32'(rsp_q[0]), 32'h1_00E5);
        check("rd_collide_done", 32'(rsp_q[1]), 32'h0_0011);

        // Reset after two bytes of an ALU_OP frame
        tick(); tick();
        tx_q.delete(); rsp_q.delete();
        issue_cmd(2'd2, 4'h0, 8'h12, 8'h34, 4'h1);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_mid_txv", 32'(tx_valid), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        check("rst_mid_sent", tx_q.size(), 2);
        check("rst_mid_b1", 32'(tx_q[1]), 32'h12);
        run_txn(model(2'd1, 4'hA, 8'h00, 8'h00, 4'h0, 8'h3E, 8'h00, 0), "after_rst");

        // Response timeout
        tx_q.delete(); rsp_q.delete();
        tmo_limit = 16'd10;
        issue_cmd(2'd1, 4'h5, 8'h00, 8'h00, 4'h0);
        wait_tx(2, "tmo");
`ifdef RSP_TIMEOUT_EN
        begin
            int n = 0;
            while (!rsp_valid && n < 50) begin tick(); n++; end
            check("tmo_latency", n, 10);
            check("tmo_rsp", {15'd0, rsp_err, rsp_data}, 32'h1_0000);
        end
`else
        repeat (1000) tick();
        check("no_tmo_rsp", rsp_q.size(), 0);
        push_rx(8'h3C);
        wait_rsp(1, "late_rsp");
        check("late_rsp", 32'(rsp_q[0]), 32'h0_003C);
`endif
        tmo_limit = 16'd0;
        tick(); tick();
        check("tmo_ready", 32'(cmd_ready), 32'd1);

        for (int k = 0; k < 40; k++)
            run_txn(model(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                          8'($urandom), 8'($urandom), $urandom_range(0, 2)), $sformatf("rnd%0d", k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
